grs_stage: RTL and testbench
============================

// Module: grs_stage
// PURPOSE
//  Parametrised operand staging buffer feeding the ALU datapath.
//  - Successor to the combinational operand gate: same zero-gating on enable, generalised in width and operand count.
//  - Adds a DEPTH-entry FIFO with valid/ready handshakes on both sides, flush, and an occupancy count.
//  - Sits between operand fetch (upstream) and the ALU (downstream); absorbs ALU stalls without losing operand sets.
// PARAMETERS
//  WIDTH  16  bits per operand
//  NOPS   2   operands per entry (op0 = X, op1 = Y, ...)
//  DEPTH  4   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1                   rising-edge clock
//  rst        in   1                   asynchronous, active-high reset
//  grs_en     in   1                   output enable; low = outputs gated to zero, no pops
//  flush      in   1                   synchronous discard of all entries
//  in_valid   in   1                   upstream operand set valid
//  in_ready   out  1                   buffer can accept (not full, not in reset)
//  in_ops     in   NOPS*WIDTH          operand set; op k at [k*WIDTH +: WIDTH]
//  out_valid  out  1                   head entry presented to ALU
//  out_ready  in   1                   ALU consumes head this cycle
//  out_ops    out  NOPS*WIDTH          head operand set, zero when out_valid low
//  count      out  $clog2(DEPTH+1)     entries held
// BEHAVIOUR
//  Reset (rst high, async):
//  - Read/write pointers = 0, count = 0.
//  - out_valid = 0, out_ops = 0, in_ready = 0 while rst is high.
//  - Storage array is not reset.
//  Transfer events:
//  - push = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - Both are evaluated on the rising edge.
//  Handshake signals:
//  - in_ready = !rst & (count != DEPTH); combinational from state only, never from in_valid.
//  - out_valid = grs_en & (count != 0); out_ops = out_valid ? mem[rd_ptr] : 0.
//  - grs_en low: head is held and count is not decremented; pushes are still accepted.
//  - Deasserting grs_en while out_valid=1 withdraws out_valid; the ALU must not rely on a consumed beat that cycle.
//  Latency and ordering:
//  - No combinational bypass: an entry pushed at edge N is visible on out_ops from cycle N+1.
//  - Minimum latency is 1 cycle; ordering is strict FIFO.
//  Pointers and count:
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - count is tracked separately, so full and empty are unambiguous.
//  - Simultaneous push & pop: count unchanged, both pointers advance.
//  - Full (count = DEPTH): in_ready = 0, no push. A same-cycle pop does not open a slot until the next cycle.
//  - Empty: out_valid = 0 regardless of out_ready.
//  Flush:
//  - flush high at an edge: pointers and count go to 0.
//  - Any push or pop in that cycle is discarded or ignored; flush has priority over both.
//  - Outputs return to zero the following cycle.
//  Reset mid-transfer:
//  - Any in-flight handshake is dropped and the FIFO is empty after rst falls.
//  - First push is allowed on the first edge with rst low.
//  Data and ranges:
//  - Operands are passed through bit-exact; no arithmetic, sign or width change.
//  - count ranges 0..DEPTH.
// TESTING
//  1. Reset then single push: in_ops={16'h0005,16'h0003}, grs_en=1
//     -> cycle+1 out_valid=1, out_ops={0005,0003}, count=1.
//  2. Fill with out_ready=0: push 4 sets (DEPTH=4)
//     -> count=4, in_ready=0; 5th in_valid is ignored; drain returns the 4 sets in order.
//  3. Continuous push+pop at full rate for 10 sets across pointer wrap
//     -> count stays 1, outputs in order, no drops or duplicates.
//  4. grs_en=0 with 2 entries held
//     -> out_valid=0, out_ops=0, count=2 held; re-enable -> original head reappears.
//  5. flush with count=3 while in_valid=1
//     -> next cycle count=0, out_valid=0; the flushed-cycle input is not stored.
//  6. Assert rst mid-stream with count=2
//     -> out_valid and out_ops go to 0 immediately (async), in_ready=0; after release count=0, in_ready=1.

Source files
------------

// File: rtl/grs_stage.sv
// Operand staging FIFO between operand fetch and the ALU.
// Head operands are zero-gated by grs_en; flush and async reset empty the buffer.
module grs_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NOPS  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         grs_en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NOPS*WIDTH-1:0]        in_ops,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NOPS*WIDTH-1:0]        out_ops,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned DW = NOPS * WIDTH;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Handshakes depend on registered state only (plus rst/grs_en), never on in_valid.
    always_comb begin
        in_ready  = !rst && (count_q != CW'(DEPTH));
        out_valid = grs_en && (count_q != '0);
        out_ops   = out_valid ? mem[rd_ptr_q] : '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        count     = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is intentionally not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= in_ops;
        end
    end

endmodule

// File: tb/tb_grs_stage.sv
// Self-checking bench for grs_stage: queue model checked every cycle plus directed literals.
module tb_grs_stage;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NOPS  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = NOPS * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          grs_en;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_ops;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_ops;
    logic [2:0]    count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];

    grs_stage #(.WIDTH(WIDTH), .NOPS(NOPS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .grs_en    (grs_en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ops   (out_ops),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference FIFO: acceptance and consumption decided from queue occupancy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            automatic bit acc = in_valid && (model_q.size() < DEPTH);
            automatic bit con = grs_en && out_ready && (model_q.size() > 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (con) void'(model_q.pop_front());
                if (acc) model_q.push_back(in_ops);
            end
        end
    end

    always @(negedge clk) begin
        automatic bit          ev = grs_en && (model_q.size() > 0);
        automatic logic [31:0] eo = ev ? model_q[0] : '0;
        chk("cyc_in_ready", 32'(in_ready), 32'(!rst && (model_q.size() < DEPTH)));
        chk("cyc_out_valid", 32'(out_valid), 32'(ev));
        chk("cyc_out_ops", out_ops, eo);
        chk("cyc_count", 32'(count), 32'(model_q.size()));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; grs_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_ops = '0; out_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // 1: single push, visible next cycle
        in_valid = 1'b1; in_ops = 32'h0005_0003;
        cycle();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_ops", out_ops, 32'h0005_0003);
        chk("t1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t1_drain_count", 32'(count), 32'd0);

        // 2: fill, 5th push ignored, drain in order
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_ops = 32'h1000 + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_ops", out_ops, 32'h1000 + 32'(i));
            cycle();
        end
        out_ready = 1'b0;
        chk("t2_empty_count", 32'(count), 32'd0);
        chk("t2_empty_valid", 32'(out_valid), 32'd0);

        // 3: full-rate push+pop across pointer wrap
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_ops = 32'h2000 + 32'(i);
            cycle();
            chk("t3_count", 32'(count), 32'd1);
            chk("t3_ops", out_ops, 32'h2000 + 32'(i));
        end
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        chk("t3_drained", 32'(count), 32'd0);

        // 4: gating with 2 entries held
        in_valid = 1'b1;
        in_ops = 32'h3000; cycle();
        in_ops = 32'h3001; cycle();
        in_valid = 1'b0;
        grs_en = 1'b0; out_ready = 1'b1;
        #1;
        chk("t4_gated_valid", 32'(out_valid), 32'd0);
        chk("t4_gated_ops", out_ops, 32'd0);
        cycle(); cycle();
        chk("t4_held_count", 32'(count), 32'd2);
        out_ready = 1'b0; grs_en = 1'b1;
        #1;
        chk("t4_head_back", out_ops, 32'h3000);

        // 5: flush with count=3 while in_valid=1
        in_valid = 1'b1; in_ops = 32'h3002;
        cycle();
        chk("t5_pre_count", 32'(count), 32'd3);
        flush = 1'b1; in_ops = 32'hDEAD_BEEF;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ops", out_ops, 32'd0);
        cycle();
        chk("t5_not_stored", 32'(count), 32'd0);

        // 6: async reset mid-stream
        in_valid = 1'b1;
        in_ops = 32'h4000; cycle();
        in_ops = 32'h4001; cycle();
        chk("t6_pre_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ops", out_ops, 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("t6_post_count", 32'(count), 32'd0);
        chk("t6_post_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_ops = 32'h5000;
        cycle();
        in_valid = 1'b0;
        chk("t6_first_push", 32'(count), 32'd1);
        chk("t6_first_ops", out_ops, 32'h5000);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
